seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with shadow/active digit buffers.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 while driving.
module seven_seg_scan_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEAD_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_load_valid,
    input  logic [1:0] i_load_digit,
    input  logic [3:0] i_load_value,
    input  logic       i_load_dp,
    output logic       o_load_ready,
    output logic       o_frame_start,
    output logic [3:0] o_Segment,
    output logic [7:0] o_SevenSegmentDisplay
);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DEAD_LAST = DIV_WIDTH'(DEAD_CYCLES - 1);

    state_t               r_state, w_state_next;
    logic [DIV_WIDTH-1:0] r_presc, w_presc_next;
    logic [1:0]           r_idx, w_idx_next;
    logic                 w_commit;
    logic                 w_write;
    logic                 w_digit_blank;

    logic [3:0] r_shadow_val [4];
    logic       r_shadow_dp  [4];
    logic [3:0] r_active_val [4];
    logic       r_active_dp  [4];

    logic [3:0] r_seg;
    logic [7:0] r_disp;
    logic       r_frame_start;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0:    enc = 7'b1000000;
            4'h1:    enc = 7'b1111001;
            4'h2:    enc = 7'b0100100;
            4'h3:    enc = 7'b0110000;
            4'h4:    enc = 7'b0011001;
            4'h5:    enc = 7'b0010010;
            4'h6:    enc = 7'b0000010;
            4'h7:    enc = 7'b1111000;
            4'h8:    enc = 7'b0000000;
            4'h9:    enc = 7'b0010000;
            4'hA:    enc = 7'b0001000;
            4'hB:    enc = 7'b0000011;
            4'hC:    enc = 7'b1000110;
            4'hD:    enc = 7'b0100001;
            4'hE:    enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_BLANK;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
        end
    end

    // The prescaler keeps counting through BLANK->DRIVE so a slot is exactly 2^DIV_WIDTH cycles.
    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_idx_next   = r_idx;
        w_commit     = 1'b0;
        if (!i_enable) begin
            w_state_next = ST_BLANK;
            w_presc_next = '0;
            w_idx_next   = '0;
        end else begin
            w_presc_next = r_presc + 1'b1;
            case (r_state)
                ST_BLANK: begin
                    if (r_presc == DEAD_LAST) begin
                        w_state_next = ST_DRIVE;
                    end
                end
                default: begin
                    if (r_presc == '1) begin
                        w_state_next = ST_BLANK;
                        w_presc_next = '0;
                        w_idx_next   = r_idx + 2'd1;
                        w_commit     = (r_idx == 2'd3);
                    end
                end
            endcase
        end
    end

    assign o_load_ready = ~w_commit;
    assign w_write      = i_load_valid & ~w_commit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow_val[i] <= '0;
                r_shadow_dp[i]  <= 1'b0;
                r_active_val[i] <= '0;
                r_active_dp[i]  <= 1'b0;
            end
        end else begin
            // Active takes the pre-write shadow; a same-cycle write lands one cycle later.
            if (w_commit || !i_enable) begin
                for (int i = 0; i < 4; i++) begin
                    r_active_val[i] <= r_shadow_val[i];
                    r_active_dp[i]  <= r_shadow_dp[i];
                end
            end
            if (w_write) begin
                r_shadow_val[i_load_digit] <= i_load_value;
                r_shadow_dp[i_load_digit]  <= i_load_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] w_zero;
    logic [3:0] w_lz;

    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
        assign w_zero[gi] = (r_active_val[gi] == 4'h0) & ~r_active_dp[gi];
        assign w_lz[gi]   = &w_zero[3:gi];
    end
    assign w_lz[0]       = 1'b0;
    assign w_digit_blank = w_lz[r_idx];
`else
    assign w_digit_blank = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seg         <= 4'b1111;
            r_disp        <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (!i_enable || r_state == ST_BLANK) begin
                r_seg  <= 4'b1111;
                r_disp <= 8'hFF;
            end else begin
                r_seg  <= ~(4'b0001 << r_idx);
                r_disp <= w_digit_blank ? 8'hFF
                                        : {~r_active_dp[r_idx], enc(r_active_val[r_idx])};
            end
        end
    end

    assign o_Segment             = r_seg;
    assign o_SevenSegmentDisplay = r_disp;
    assign o_frame_start         = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (DIV_WIDTH=4, DEAD_CYCLES=2) against a timeline-based model.
module tb_seven_seg_scan_ctrl;

    localparam int DW    = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       lv  = 1'b0;
    logic [1:0] ld  = 2'd0;
    logic [3:0] lval = 4'd0;
    logic       ldp = 1'b0;
    logic       o_load_ready, o_frame_start;
    logic [3:0] o_Segment;
    logic [7:0] o_SevenSegmentDisplay;

    seven_seg_scan_ctrl #(.DIV_WIDTH(DW), .DEAD_CYCLES(DEAD)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_enable(en),
        .i_load_valid(lv),
        .i_load_digit(ld),
        .i_load_value(lval),
        .i_load_dp(ldp),
        .o_load_ready(o_load_ready),
        .o_frame_start(o_frame_start),
        .o_Segment(o_Segment),
        .o_SevenSegmentDisplay(o_SevenSegmentDisplay)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    logic [6:0] ENC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the position (0..63) within the frame timeline since the last restart.
    logic [3:0] m_sv [4];
    logic       m_sd [4];
    logic [3:0] m_av [4];
    logic       m_ad [4];
    int         m_t;
    logic [3:0] e_seg;
    logic [7:0] e_disp;
    logic       e_fs;

    function automatic logic [7:0] m_pattern(input int idx);
        bit blank;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0) begin
            blank = 1'b1;
            for (int m = idx; m < 4; m++)
                if (m_av[m] != 4'h0 || m_ad[m]) blank = 1'b0;
        end
`endif
        return blank ? 8'hFF : {~m_ad[idx], ENC[m_av[idx]]};
    endfunction

    function automatic bit m_commit_now(input logic e);
        int phase, idx;
        phase = m_t % SLOT;
        idx   = m_t / SLOT;
        return e && idx == 3 && phase == SLOT - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_sv[i] = 4'h0; m_sd[i] = 1'b0; m_av[i] = 4'h0; m_ad[i] = 1'b0;
            end
            m_t = 0; e_seg = 4'hF; e_disp = 8'hFF; e_fs = 1'b0;
        end else begin
            int phase, idx;
            bit c;
            phase = m_t % SLOT;
            idx   = m_t / SLOT;
            c     = m_commit_now(en);
            e_fs  = c;
            if (en && phase >= DEAD) begin
                e_seg  = ~(4'b0001 << idx);
                e_disp = m_pattern(idx);
            end else begin
                e_seg  = 4'hF;
                e_disp = 8'hFF;
            end
            if (!en || c)
                for (int i = 0; i < 4; i++) begin
                    m_av[i] = m_sv[i]; m_ad[i] = m_sd[i];
                end
            if (lv && !c) begin
                m_sv[ld] = lval; m_sd[ld] = ldp;
            end
            m_t = en ? (m_t + 1) % FRAME : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            if (rst) begin
                check("m_rst_seg", {4'h0, o_Segment}, 8'h0F);
                check("m_rst_disp", o_SevenSegmentDisplay, 8'hFF);
                check("m_rst_ready", {7'h0, o_load_ready}, 8'h01);
                check("m_rst_fs", {7'h0, o_frame_start}, 8'h00);
            end else begin
                check("m_seg", {4'h0, o_Segment}, {4'h0, e_seg});
                check("m_disp", o_SevenSegmentDisplay, e_disp);
                check("m_fs", {7'h0, o_frame_start}, {7'h0, e_fs});
                check("m_ready", {7'h0, o_load_ready}, {7'h0, ~m_commit_now(en)});
            end
        end
    end

    task automatic wait_seg(input logic [3:0] target);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_Segment == target) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_seg timeout: got %b expected %b", o_Segment, target);
    endtask

    task automatic wait_fs();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (o_frame_start) return;
        end
        n_checks++; n_fail++;
        $display("FAIL wait_fs timeout: got 0 expected 1");
    endtask

    task automatic do_write(input logic [1:0] d, input logic [3:0] v, input logic p);
        logic r;
        @(negedge clk);
        #1 lv = 1'b1; ld = d; lval = v; ldp = p;
        for (int n = 0; n < 200; n++) begin
            #1 r = o_load_ready;
            @(negedge clk);
            if (r) begin
                #1 lv = 1'b0;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("FAIL write timeout: got ready 0 expected 1");
        #1 lv = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        check("reset_seg", {4'h0, o_Segment}, 8'h0F);
        check("reset_disp", o_SevenSegmentDisplay, 8'hFF);
        check("reset_ready", {7'h0, o_load_ready}, 8'h01);
        check("reset_fs", {7'h0, o_frame_start}, 8'h00);

        // Scan timing from a fresh start
        @(negedge clk);
        #1 en = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2 || k == 17 || k == 18) check("t_dark", {4'h0, o_Segment}, 8'h0F);
            if (k == 3 || k == 16) check("t_d0", {4'h0, o_Segment}, 8'h0E);
            if (k == 19) check("t_d1", {4'h0, o_Segment}, 8'h0D);
            if (k == 63) check("t_ready_lo", {7'h0, o_load_ready}, 8'h00);
            if (k == 64) check("t_ready_hi", {7'h0, o_load_ready}, 8'h01);
            if (k == 63 || k == 65) check("t_fs_lo", {7'h0, o_frame_start}, 8'h00);
            if (k == 64 || k == 128) check("t_fs_hi", {7'h0, o_frame_start}, 8'h01);
        end

        // Atomic commit
        wait_seg(4'b1110);
        check("old_d0", o_SevenSegmentDisplay, 8'hC0);
        do_write(2'd0, 4'h1, 1'b0);
        do_write(2'd1, 4'h2, 1'b0);
        do_write(2'd2, 4'h3, 1'b0);
        do_write(2'd3, 4'h4, 1'b0);
        wait_seg(4'b1101);
`ifdef LEADING_ZERO_BLANK_EN
        check("old_d1", o_SevenSegmentDisplay, 8'hFF);
`else
        check("old_d1", o_SevenSegmentDisplay, 8'hC0);
`endif
        wait_fs();
        wait_seg(4'b1110); check("new_d0", o_SevenSegmentDisplay, 8'hF9);
        wait_seg(4'b1101); check("new_d1", o_SevenSegmentDisplay, 8'hA4);
        wait_seg(4'b1011); check("new_d2", o_SevenSegmentDisplay, 8'hB0);
        wait_seg(4'b0111); check("new_d3", o_SevenSegmentDisplay, 8'h99);

        // Handshake stall across the commit cycle
        wait_fs();
        repeat (63) @(negedge clk);
        #1 lv = 1'b1; ld = 2'd2; lval = 4'hA; ldp = 1'b1;
        #1 check("stall_ready0", {7'h0, o_load_ready}, 8'h00);
        @(negedge clk);
        check("stall_fs", {7'h0, o_frame_start}, 8'h01);
        #1 check("stall_ready1", {7'h0, o_load_ready}, 8'h01);
        @(negedge clk);
        #1 lv = 1'b0;
        wait_fs();
        wait_seg(4'b1011); check("stall_d2", o_SevenSegmentDisplay, 8'h08);

        // Disable mid-drive of digit 2, load, re-enable
        wait_seg(4'b1011);
        #1 en = 1'b0;
        @(negedge clk);
        check("dis_seg", {4'h0, o_Segment}, 8'h0F);
        check("dis_disp", o_SevenSegmentDisplay, 8'hFF);
        do_write(2'd0, 4'h5, 1'b0);
        repeat (3) @(negedge clk);
        check("dis_seg2", {4'h0, o_Segment}, 8'h0F);
        #1 en = 1'b1;
        @(negedge clk); check("re_dark1", {4'h0, o_Segment}, 8'h0F);
        @(negedge clk); check("re_dark2", {4'h0, o_Segment}, 8'h0F);
        @(negedge clk);
        check("re_seg", {4'h0, o_Segment}, 8'h0E);
        check("re_disp", o_SevenSegmentDisplay, 8'h92);

`ifdef LEADING_ZERO_BLANK_EN
        do_write(2'd3, 4'h0, 1'b0);
        do_write(2'd2, 4'h0, 1'b0);
        do_write(2'd1, 4'h7, 1'b0);
        do_write(2'd0, 4'h0, 1'b0);
        wait_fs();
        wait_seg(4'b1110); check("lz_d0", o_SevenSegmentDisplay, 8'hC0);
        wait_seg(4'b1101); check("lz_d1", o_SevenSegmentDisplay, 8'hF8);
        wait_seg(4'b1011); check("lz_d2", o_SevenSegmentDisplay, 8'hFF);
        wait_seg(4'b0111); check("lz_d3", o_SevenSegmentDisplay, 8'hFF);
`endif

        // Asynchronous reset while driving
        for (int n = 0; n < 40 && o_Segment == 4'hF; n++) @(negedge clk);
        check("pre_rst_drive", {7'h0, (o_Segment != 4'hF)}, 8'h01);
        #1 rst = 1'b1;
        #1;
        check("arst_seg", {4'h0, o_Segment}, 8'h0F);
        check("arst_disp", o_SevenSegmentDisplay, 8'hFF);
        check("arst_ready", {7'h0, o_load_ready}, 8'h01);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Randomized traffic with bursts of disable and one extra reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (i == 1500) rst = 1'b1;
            if (i == 1502) rst = 1'b0;
            if (en) en = ($urandom_range(0, 199) != 0);
            else    en = ($urandom_range(0, 4) == 0);
            lv   = ($urandom_range(0, 3) == 0);
            ld   = 2'($urandom_range(0, 3));
            lval = 4'($urandom_range(0, 15));
            ldp  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #1 lv = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
